// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU enums for the digit-serial
// two's-complement unit.
package alu_pkg;

   typedef enum logic [1:0] {
      TC_SEXT,
      TC_NEG,
      TC_ABS,
      TC_RSVD
   } tc_mode_e;

   typedef enum logic [1:0] {
      TC_IDLE,
      TC_RUN,
      TC_DONE
   } tc_state_e;

endpackage

// File: rtl/twoc_digit.sv
// twoc_digit: one DIGIT_W slice of the carry chain,
// optionally inverting x before the add.
module twoc_digit #(
   parameter int DIGIT_W = 2
) (
   input  logic [DIGIT_W-1:0] x_i,
   input  logic               inv_i,
   input  logic               cin_i,
   output logic [DIGIT_W-1:0] s_o,
   output logic               cout_o
);

   logic [DIGIT_W-1:0] xo;

   assign xo = inv_i ? ~x_i : x_i;
   assign {cout_o, s_o} = {1'b0, xo} + {{DIGIT_W{1'b0}}, cin_i};

endmodule

// File: rtl/twos_complement_serial.sv
// twos_complement_serial: digit-serial SEXT / NEG / ABS.
// Define TWOCOMP_OVF_EN to flag unrepresentable negations.
module twos_complement_serial
   import alu_pkg::*;
#(
   parameter int IN_W    = 3,
   parameter int OUT_W   = 6,
   parameter int DIGIT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_a,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_s,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NDIG = OUT_W / DIGIT_W;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

   if (OUT_W < IN_W || DIGIT_W < 1 || (OUT_W % DIGIT_W) != 0) begin : g_bad
      $error("twos_complement_serial: illegal IN_W/OUT_W/DIGIT_W");
   end

   tc_state_e          state_q, state_d;
   logic [OUT_W-1:0]   ext_q, ext_d;
   logic [OUT_W-1:0]   res_q, res_d;
   logic [OUT_W-1:0]   ext_in;
   logic [KW-1:0]      k_q, k_d;
   logic               carry_q, carry_d;
   logic               inv_q, inv_d;
   logic               cout_q, cout_d;
   logic [DIGIT_W-1:0] dig_s;
   logic               dig_c;
   logic               accept;
   logic               inv_in;
   tc_mode_e           mode_in;

   assign mode_in  = tc_mode_e'(in_mode);
   assign in_ready = (state_q == TC_IDLE);
   assign accept   = in_valid && in_ready;
   assign inv_in   = (mode_in == TC_NEG) ||
                     ((mode_in == TC_ABS) && in_a[IN_W-1]);

   twoc_digit #(.DIGIT_W(DIGIT_W)) u_digit (
      .x_i    (ext_q[DIGIT_W-1:0]),
      .inv_i  (inv_q),
      .cin_i  (carry_q),
      .s_o    (dig_s),
      .cout_o (dig_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TC_IDLE;
         ext_q   <= '0;
         res_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         inv_q   <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ext_q   <= ext_d;
         res_q   <= res_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         inv_q   <= inv_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ext_d   = ext_q;
      res_d   = res_q;
      k_d     = k_q;
      carry_d = carry_q;
      inv_d   = inv_q;
      cout_d  = cout_q;
      ext_in  = {OUT_W{in_a[IN_W-1]}};
      ext_in[IN_W-1:0] = in_a;
      unique case (state_q)
         TC_IDLE: begin
            if (accept) begin
               state_d = TC_RUN;
               ext_d   = ext_in;
               inv_d   = inv_in;
               carry_d = inv_in;
               k_d     = '0;
               cout_d  = 1'b0;
            end
         end
         TC_RUN: begin
            // Result fills from the top; after NDIG shifts digit 0 sits at LSB.
            ext_d   = ext_q >> DIGIT_W;
            res_d   = res_q >> DIGIT_W;
            res_d[OUT_W-1 -: DIGIT_W] = dig_s;
            carry_d = dig_c;
            k_d     = k_q + KW'(1);
            if (k_q == KLAST) begin
               cout_d  = dig_c;
               state_d = TC_DONE;
            end
         end
         TC_DONE: begin
            if (out_ready) state_d = TC_IDLE;
         end
         default: state_d = TC_IDLE;
      endcase
   end

   assign out_valid = (state_q == TC_DONE);
   assign out_s     = res_q;
   assign out_cout  = cout_q;

`ifdef TWOCOMP_OVF_EN
   localparam logic [IN_W-1:0] AMIN = IN_W'(1) << (IN_W - 1);
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ovf_q <= 1'b0;
      else if (accept) ovf_q <= inv_in && (in_a == AMIN);
   end

   assign out_ovf = ovf_q && out_valid;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_twos_complement_serial.sv
// tb_twos_complement_serial: directed + random ops checked
// against an arithmetic model of SEXT/NEG/ABS.
module tb_twos_complement_serial;

   localparam int NDIG = 3;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_a;
   logic [1:0] in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_s;
   logic       out_cout;
   logic       out_ovf;

   int nchk;
   int nfail;
   int cyc;

   typedef struct {
      logic [5:0] s;
      logic       c;
      logic       o;
      int         acc;
   } exp_t;

   exp_t q[$];
   bit   seen;

   twos_complement_serial #(.IN_W(3), .OUT_W(6), .DIGIT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [2:0] a, input logic [1:0] m);
      exp_t e;
      int   v;
      int   r;
      bit   inv;
      v   = $signed(a);
      inv = (m == 2'd1) || (m == 2'd2 && v < 0);
      r   = inv ? -v : v;
      e.s = r[5:0];
      e.c = inv && (v == 0);
`ifdef TWOCOMP_OVF_EN
      e.o = inv && (v == -4);
`else
      e.o = 1'b0;
`endif
      e.acc = 0;
      return e;
   endfunction

   // Single compare process: every negedge the DUT is held to the model.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         seen = 0;
         chk("rst_valid", int'(out_valid), 0);
         chk("rst_s", int'(out_s), 0);
         chk("rst_ready", int'(in_ready), 1);
      end else begin
         chk("in_ready", int'(in_ready), int'(q.size() == 0));
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               if (!seen) chk("latency", cyc, q[0].acc + NDIG + 1);
               seen = 1;
               chk("out_s", int'(out_s), int'(q[0].s));
               chk("out_cout", int'(out_cout), int'(q[0].c));
               chk("out_ovf", int'(out_ovf), int'(q[0].o));
               if (out_ready) begin
                  void'(q.pop_front());
                  seen = 0;
               end
            end
         end
         if (in_valid && in_ready) begin
            e     = model(in_a, in_mode);
            e.acc = cyc;
            q.push_back(e);
         end
      end
   end

   task automatic op(input logic [2:0] a, input logic [1:0] m,
                     input int hold, input bit lit,
                     input logic [5:0] es, input logic ec, input logic eo);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) chk("wait_ready", 0, 1);
      in_a     = a;
      in_mode  = m;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = 3'($urandom);
      in_mode  = 2'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!out_valid) begin
         chk("timeout_valid", 0, 1);
         return;
      end
      if (lit) begin
         chk("lit_s", int'(out_s), int'(es));
         chk("lit_cout", int'(out_cout), int'(ec));
         chk("lit_ovf", int'(out_ovf), int'(eo));
      end
      repeat (hold) begin
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_valid", int'(out_valid), 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic ovf_min;

   initial begin
      nchk      = 0;
      nfail     = 0;
      cyc       = 0;
      seen      = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_mode   = '0;
      out_ready = 1'b0;
`ifdef TWOCOMP_OVF_EN
      ovf_min = 1'b1;
`else
      ovf_min = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cout", int'(out_cout), 0);
      chk("reset_ovf", int'(out_ovf), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op(3'b101, 2'd1, 0, 1, 6'b000011, 1'b0, 1'b0);
      op(3'b000, 2'd1, 0, 1, 6'b000000, 1'b1, 1'b0);
      op(3'b110, 2'd1, 0, 1, 6'b000010, 1'b0, 1'b0);
      op(3'b111, 2'd2, 0, 1, 6'b000001, 1'b0, 1'b0);
      op(3'b011, 2'd2, 0, 1, 6'b000011, 1'b0, 1'b0);
      op(3'b101, 2'd0, 0, 1, 6'b111101, 1'b0, 1'b0);
      op(3'b101, 2'd3, 0, 1, 6'b111101, 1'b0, 1'b0);
      op(3'b100, 2'd1, 0, 1, 6'b000100, 1'b0, ovf_min);
      op(3'b100, 2'd2, 0, 1, 6'b000100, 1'b0, ovf_min);
      op(3'b010, 2'd1, 5, 1, 6'b111110, 1'b0, 1'b0);
      op(3'b001, 2'd1, 0, 1, 6'b111111, 1'b0, 1'b0);

      // Abort during digit 1 of a run.
      in_a     = 3'b011;
      in_mode  = 2'd1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", int'(out_valid), 0);
      chk("abort_s", int'(out_s), 0);
      chk("abort_ready", int'(in_ready), 1);
      chk("abort_cout", int'(out_cout), 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      op(3'b011, 2'd1, 0, 1, 6'b111101, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         op(3'($urandom), 2'($urandom), $urandom_range(0, 3),
            0, 6'b0, 1'b0, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end

endmodule
